// File: rtl/alu_pipe_if.sv
// Issue/result bus of the integer ALU: operands in, rd/value/sid out, with valid/ready on both sides.
interface alu_pipe_if #(
   parameter int XLEN  = 64,
   parameter int SID_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [SID_W-1:0] in_sid;
   logic [XLEN-1:0]  in_pc;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  rs1_value;
   logic [XLEN-1:0]  rs2_value;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [SID_W-1:0] out_sid;
   logic [4:0]       out_rd;
   logic [XLEN-1:0]  out_rd_value;
   logic             out_illegal;

   modport master (
      output in_valid, in_sid, in_pc, in_inst, rs1_value, rs2_value, flush, out_ready,
      input  in_ready, out_valid, out_sid, out_rd, out_rd_value, out_illegal
   );

   modport slave (
      input  in_valid, in_sid, in_pc, in_inst, rs1_value, rs2_value, flush, out_ready,
      output in_ready, out_valid, out_sid, out_rd, out_rd_value, out_illegal
   );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined RV32I/RV64I integer ALU with valid/ready backpressure, flush and illegal-op flagging.
// XLEN must be 32 or 64; STAGES (1..4) is the latency with no backpressure.
module alu_pipe #(
   parameter int XLEN   = 64,
   parameter int STAGES = 1,
   parameter int SID_W  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] F7_ZERO      = 7'b0000000;
   localparam logic [6:0] F7_ALT       = 7'b0100000;

   logic             s0_valid;
   logic [SID_W-1:0] s0_sid;
   logic [XLEN-1:0]  s0_pc;
   logic [31:0]      s0_inst;
   logic [XLEN-1:0]  s0_rs1;
   logic [XLEN-1:0]  s0_rs2;
   logic             s0_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_sid   <= '0;
         s0_pc    <= '0;
         s0_inst  <= '0;
         s0_rs1   <= '0;
         s0_rs2   <= '0;
      end else begin
         if (bus.flush)
            s0_valid <= 1'b0;
         else if (s0_adv)
            s0_valid <= bus.in_valid;
         if (s0_adv && bus.in_valid && !bus.flush) begin
            s0_sid  <= bus.in_sid;
            s0_pc   <= bus.in_pc;
            s0_inst <= bus.in_inst;
            s0_rs1  <= bus.rs1_value;
            s0_rs2  <= bus.rs2_value;
         end
      end
   end

   assign bus.in_ready = s0_adv;

   // ---------------------------------------------------------------- execute
   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic [6:0]             funct7;
   logic                   is_reg;
   logic                   sub_sel;
   logic [XLEN-1:0]        imm_i;
   logic [XLEN-1:0]        imm_u;
   logic [XLEN-1:0]        op_a;
   logic [XLEN-1:0]        op_b;
   logic signed [XLEN-1:0] op_a_s;
   logic [5:0]             shamt;
   logic [XLEN-1:0]        add_sub;
   logic [XLEN-1:0]        sll_v;
   logic [XLEN-1:0]        srl_v;
   logic [XLEN-1:0]        sra_v;
   logic                   lt_s;
   logic                   lt_u;
   logic [31:0]            w_a;
   logic [31:0]            w_b;
   logic signed [31:0]     w_a_s;
   logic [4:0]             w_sh;
   logic [31:0]            w_sum;
   logic [31:0]            w_sll;
   logic [31:0]            w_srl;
   logic signed [31:0]     w_sra;
   logic signed [31:0]     w_res;
   logic [XLEN-1:0]        res_value;
   logic                   res_ill;
   logic                   unused_rs1_idx;

   assign opcode  = s0_inst[6:0];
   assign funct3  = s0_inst[14:12];
   assign funct7  = s0_inst[31:25];
   assign is_reg  = (opcode == OPC_OP) || (opcode == OPC_OP32);
   // On ADDI/ADDIW bit 30 belongs to the immediate, so only register forms may subtract
   assign sub_sel = is_reg && s0_inst[30];
   assign imm_i   = {{(XLEN-12){s0_inst[31]}}, s0_inst[31:20]};
   assign imm_u   = XLEN'($signed({s0_inst[31:12], 12'h000}));
   assign op_a    = s0_rs1;
   assign op_b    = is_reg ? s0_rs2 : imm_i;
   assign op_a_s  = op_a;
   assign shamt   = (XLEN == 64) ? op_b[5:0] : {1'b0, op_b[4:0]};
   assign add_sub = sub_sel ? (op_a - op_b) : (op_a + op_b);
   assign sll_v   = op_a << shamt;
   assign srl_v   = op_a >> shamt;
   assign sra_v   = op_a_s >>> shamt;
   assign lt_s    = $signed(op_a) < $signed(op_b);
   assign lt_u    = op_a < op_b;

   assign w_a     = op_a[31:0];
   assign w_b     = op_b[31:0];
   assign w_a_s   = w_a;
   assign w_sh    = op_b[4:0];
   assign w_sum   = sub_sel ? (w_a - w_b) : (w_a + w_b);
   assign w_sll   = w_a << w_sh;
   assign w_srl   = w_a >> w_sh;
   assign w_sra   = w_a_s >>> w_sh;

   assign unused_rs1_idx = ^s0_inst[19:15];

   always_comb begin
      res_value = '0;
      res_ill   = 1'b0;
      w_res     = '0;
      case (opcode)
         OPC_OP_IMM, OPC_OP: begin
            case (funct3)
               3'b000:  res_value = add_sub;
               3'b001:  res_value = sll_v;
               3'b010:  res_value = XLEN'(lt_s);
               3'b011:  res_value = XLEN'(lt_u);
               3'b100:  res_value = op_a ^ op_b;
               3'b101:  res_value = s0_inst[30] ? sra_v : srl_v;
               3'b110:  res_value = op_a | op_b;
               default: res_value = op_a & op_b;
            endcase
            if (opcode == OPC_OP)
               res_ill = !((funct7 == F7_ZERO) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            else if (funct3 == 3'b001)
               res_ill = (s0_inst[31:26] != 6'd0) || ((XLEN == 32) && s0_inst[25]);
            else if (funct3 == 3'b101)
               res_ill = s0_inst[31] || (s0_inst[29:26] != 4'd0) || ((XLEN == 32) && s0_inst[25]);
         end
         OPC_LUI:   res_value = imm_u;
         OPC_AUIPC: res_value = s0_pc + imm_u;
         OPC_OP_IMM32, OPC_OP32: begin
            case (funct3)
               3'b000: begin
                  w_res   = w_sum;
                  res_ill = (opcode == OPC_OP32) && (funct7 != F7_ZERO) && (funct7 != F7_ALT);
               end
               3'b001: begin
                  w_res   = w_sll;
                  res_ill = funct7 != F7_ZERO;
               end
               3'b101: begin
                  w_res   = s0_inst[30] ? w_sra : w_srl;
                  res_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
               end
               default: res_ill = 1'b1;
            endcase
            res_value = XLEN'(w_res);
            if (XLEN != 64)
               res_ill = 1'b1;
         end
         default: res_ill = 1'b1;
      endcase
      if (res_ill)
         res_value = '0;
   end

   // ---------------------------------------------------------------- result stages
   generate
      if (STAGES == 1) begin : g_direct
         assign s0_adv           = ~s0_valid | bus.out_ready;
         assign bus.out_valid    = s0_valid;
         assign bus.out_sid      = s0_sid;
         assign bus.out_rd       = s0_inst[11:7];
         assign bus.out_rd_value = res_value;
         assign bus.out_illegal  = s0_valid & res_ill;
      end else begin : g_pipe
         localparam int N = STAGES - 1;

         logic [N-1:0]     valid_reg;
         logic [N-1:0]     ill_reg;
         logic [N-1:0]     adv;
         logic [N-1:0]     src_valid;
         logic [N-1:0]     src_ill;
         logic [SID_W-1:0] sid_reg   [N];
         logic [4:0]       rd_reg    [N];
         logic [XLEN-1:0]  value_reg [N];
         logic [SID_W-1:0] src_sid   [N];
         logic [4:0]       src_rd    [N];
         logic [XLEN-1:0]  src_value [N];

         // A stage moves when any slot from it to the output is free or the output drains
         assign s0_adv = bus.out_ready | ~s0_valid | ~(&valid_reg);

         for (genvar gi = 0; gi < N; gi++) begin : g_link
            assign adv[gi] = bus.out_ready | ~(&valid_reg[N-1:gi]);
            if (gi == 0) begin : g_head
               assign src_valid[gi] = s0_valid;
               assign src_ill[gi]   = res_ill;
               assign src_sid[gi]   = s0_sid;
               assign src_rd[gi]    = s0_inst[11:7];
               assign src_value[gi] = res_value;
            end else begin : g_body
               assign src_valid[gi] = valid_reg[gi-1];
               assign src_ill[gi]   = ill_reg[gi-1];
               assign src_sid[gi]   = sid_reg[gi-1];
               assign src_rd[gi]    = rd_reg[gi-1];
               assign src_value[gi] = value_reg[gi-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= '0;
               ill_reg   <= '0;
               for (int k = 0; k < N; k++) begin
                  sid_reg[k]   <= '0;
                  rd_reg[k]    <= '0;
                  value_reg[k] <= '0;
               end
            end else begin
               for (int k = 0; k < N; k++) begin
                  if (bus.flush)
                     valid_reg[k] <= 1'b0;
                  else if (adv[k])
                     valid_reg[k] <= src_valid[k];
                  if (adv[k] && src_valid[k] && !bus.flush) begin
                     ill_reg[k]   <= src_ill[k];
                     sid_reg[k]   <= src_sid[k];
                     rd_reg[k]    <= src_rd[k];
                     value_reg[k] <= src_value[k];
                  end
               end
            end
         end

         assign bus.out_valid    = valid_reg[N-1];
         assign bus.out_sid      = sid_reg[N-1];
         assign bus.out_rd       = rd_reg[N-1];
         assign bus.out_rd_value = value_reg[N-1];
         assign bus.out_illegal  = ill_reg[N-1];
      end
   endgenerate
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: vector tables on a 64-bit/1-stage and a 32-bit/2-stage ALU,
// plus backpressure, flush and async-reset sequences on a 64-bit/3-stage ALU.
module tb_alu_pipe;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OP_REG32 = 7'b0111011;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.XLEN(64), .SID_W(4)) b1  ();
   alu_pipe_if #(.XLEN(64), .SID_W(4)) b3  ();
   alu_pipe_if #(.XLEN(32), .SID_W(4)) b32 ();

   alu_pipe #(.XLEN(64), .STAGES(1), .SID_W(4)) dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
   alu_pipe #(.XLEN(64), .STAGES(3), .SID_W(4)) dut3  (.clk(clk), .rst_n(rst_n), .bus(b3));
   alu_pipe #(.XLEN(32), .STAGES(2), .SID_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] exp_value;
      logic        exp_ill;
   } vec_t;

   vec_t q64[$];
   vec_t q32[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
      return {imm, 5'd1, f3, 5'd0, opc};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, 5'd0, opc};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] opc);
      return {imm, 5'd0, opc};
   endfunction

   task automatic add_vec(input bit wide, input string nm, input logic [31:0] inst, input logic [63:0] pc,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] expv, input logic ill);
      vec_t v;
      v.name = nm; v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.exp_value = expv; v.exp_ill = ill;
      v.inst[11:7] = wide ? 5'(q64.size() + 5) : 5'(q32.size() + 20);
      if (wide) q64.push_back(v);
      else      q32.push_back(v);
   endtask

   task automatic run64(input vec_t v, input logic [3:0] sid);
      b1.in_valid = 1'b1; b1.in_sid = sid; b1.in_pc = v.pc; b1.in_inst = v.inst;
      b1.rs1_value = v.rs1; b1.rs2_value = v.rs2;
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      chk({v.name, ".valid"}, 64'(b1.out_valid), 64'd1);
      chk({v.name, ".sid"}, 64'(b1.out_sid), 64'(sid));
      chk({v.name, ".rd"}, 64'(b1.out_rd), 64'(v.inst[11:7]));
      chk({v.name, ".value"}, b1.out_rd_value, v.exp_value);
      chk({v.name, ".illegal"}, 64'(b1.out_illegal), 64'(v.exp_ill));
      $display("tx x64 %-8s sid=%0d rd=%0d value=%h ill=%0b", v.name, b1.out_sid, b1.out_rd, b1.out_rd_value, b1.out_illegal);
   endtask

   task automatic run32(input vec_t v, input logic [3:0] sid);
      b32.in_valid = 1'b1; b32.in_sid = sid; b32.in_pc = v.pc[31:0]; b32.in_inst = v.inst;
      b32.rs1_value = v.rs1[31:0]; b32.rs2_value = v.rs2[31:0];
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      chk({v.name, ".early"}, 64'(b32.out_valid), 64'd0);
      @(posedge clk); #1;
      chk({v.name, ".valid"}, 64'(b32.out_valid), 64'd1);
      chk({v.name, ".sid"}, 64'(b32.out_sid), 64'(sid));
      chk({v.name, ".rd"}, 64'(b32.out_rd), 64'(v.inst[11:7]));
      chk({v.name, ".value"}, 64'(b32.out_rd_value), v.exp_value);
      chk({v.name, ".illegal"}, 64'(b32.out_illegal), 64'(v.exp_ill));
      $display("tx x32 %-8s sid=%0d rd=%0d value=%h ill=%0b", v.name, b32.out_sid, b32.out_rd, b32.out_rd_value, b32.out_illegal);
   endtask

   task automatic drive3(input int sid);
      b3.in_valid  = 1'b1;
      b3.in_sid    = 4'(sid);
      b3.in_inst   = enc_i(12'(sid), 3'b000, OP_IMM);
      b3.in_inst[11:7] = 5'(sid);
      b3.rs1_value = 64'(sid * 16);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          next_sid;
      int          got;
      logic [3:0]  hold_sid;
      logic [63:0] hold_val;

      b1.in_valid = 0; b1.in_sid = 0; b1.in_pc = 0; b1.in_inst = 0; b1.rs1_value = 0; b1.rs2_value = 0;
      b1.flush = 0; b1.out_ready = 1;
      b3.in_valid = 0; b3.in_sid = 0; b3.in_pc = 0; b3.in_inst = 0; b3.rs1_value = 0; b3.rs2_value = 0;
      b3.flush = 0; b3.out_ready = 1;
      b32.in_valid = 0; b32.in_sid = 0; b32.in_pc = 0; b32.in_inst = 0; b32.rs1_value = 0; b32.rs2_value = 0;
      b32.flush = 0; b32.out_ready = 1;

      add_vec(1, "addi",   enc_i(12'hFF8, 3'b000, OP_IMM), 0, 64'd7, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      add_vec(1, "slt",    enc_r(7'h00, 3'b010, OP_REG), 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0);
      add_vec(1, "sltu",   enc_r(7'h00, 3'b011, OP_REG), 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
      add_vec(1, "sraw",   enc_r(7'h20, 3'b101, OP_REG32), 0, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 0);
      add_vec(1, "addiw",  enc_i(12'h001, 3'b000, OP_IMM32), 0, 64'h7FFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000, 0);
      add_vec(1, "sub",    enc_r(7'h20, 3'b000, OP_REG), 0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      add_vec(1, "srai63", enc_i(12'h43F, 3'b101, OP_IMM), 0, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      add_vec(1, "srli63", enc_i(12'h03F, 3'b101, OP_IMM), 0, 64'h8000_0000_0000_0000, 0, 64'd1, 0);
      add_vec(1, "lui",    enc_u(20'h80000, OP_LUI), 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 0);
      add_vec(1, "auipc",  enc_u(20'h00001, OP_AUIPC), 64'h1000, 0, 0, 64'h2000, 0);
      add_vec(1, "sll",    enc_r(7'h00, 3'b001, OP_REG), 0, 64'd3, 64'h41, 64'd6, 0);
      add_vec(1, "mul",    enc_r(7'h01, 3'b000, OP_REG), 0, 64'd3, 64'd5, 64'd0, 1);
      add_vec(1, "xori",   enc_i(12'hFFF, 3'b100, OP_IMM), 0, 64'hF0, 0, 64'hFFFF_FFFF_FFFF_FF0F, 0);
      add_vec(1, "slti",   enc_i(12'hFFD, 3'b010, OP_IMM), 0, 64'hFFFF_FFFF_FFFF_FFFB, 0, 64'd1, 0);
      add_vec(1, "sltiu",  enc_i(12'hFFF, 3'b011, OP_IMM), 0, 64'd0, 0, 64'd1, 0);
      add_vec(1, "sllw",   enc_r(7'h00, 3'b001, OP_REG32), 0, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 0);
      add_vec(1, "w_f3bad",enc_i(12'h001, 3'b010, OP_IMM32), 0, 64'd9, 0, 64'd0, 1);
      add_vec(1, "srliw25",enc_i(12'h020, 3'b101, OP_IMM32), 0, 64'hFF, 0, 64'd0, 1);
      add_vec(1, "andi",   enc_i(12'h0F0, 3'b111, OP_IMM), 0, 64'hFF, 0, 64'hF0, 0);
      add_vec(1, "subw",   enc_r(7'h20, 3'b000, OP_REG32), 0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);

      add_vec(0, "addiw32",enc_i(12'h001, 3'b000, OP_IMM32), 0, 64'd5, 0, 64'd0, 1);
      add_vec(0, "slli25", enc_i(12'h021, 3'b001, OP_IMM), 0, 64'd1, 0, 64'd0, 1);
      add_vec(0, "auipc32",enc_u(20'h00001, OP_AUIPC), 64'h1000, 0, 0, 64'h2000, 0);
      add_vec(0, "srai32", enc_i(12'h404, 3'b101, OP_IMM), 0, 64'h8000_0000, 0, 64'hF800_0000, 0);
      add_vec(0, "slt32",  enc_r(7'h00, 3'b010, OP_REG), 0, 64'hFFFF_FFFF, 64'd1, 64'd1, 0);
      add_vec(0, "sltu32", enc_r(7'h00, 3'b011, OP_REG), 0, 64'hFFFF_FFFF, 64'd1, 64'd0, 0);
      add_vec(0, "addwrap",enc_r(7'h00, 3'b000, OP_REG), 0, 64'hFFFF_FFFF, 64'd2, 64'd1, 0);
      add_vec(0, "sll32",  enc_r(7'h00, 3'b001, OP_REG), 0, 64'd1, 64'h21, 64'd2, 0);
      add_vec(0, "lui32",  enc_u(20'h80000, OP_LUI), 0, 0, 0, 64'h8000_0000, 0);

      // Reset state while rst_n is still low
      repeat (2) @(posedge clk);
      #1;
      chk("rst.x64.out_valid", 64'(b1.out_valid), 64'd0);
      chk("rst.x64.in_ready", 64'(b1.in_ready), 64'd1);
      chk("rst.x64.value", b1.out_rd_value, 64'd0);
      chk("rst.x64.illegal", 64'(b1.out_illegal), 64'd0);
      chk("rst.x64.sid_rd", 64'({b1.out_sid, b1.out_rd}), 64'd0);
      chk("rst.s3.out_valid", 64'(b3.out_valid), 64'd0);
      chk("rst.s3.in_ready", 64'(b3.in_ready), 64'd1);
      chk("rst.s3.illegal", 64'(b3.out_illegal), 64'd0);
      chk("rst.x32.out_valid", 64'(b32.out_valid), 64'd0);
      chk("rst.x32.illegal", 64'(b32.out_illegal), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (q64[i]) run64(q64[i], 4'(i));
      foreach (q32[i]) run32(q32[i], 4'(i + 9));

      // Backpressure: sids 1..6 back-to-back, out_ready low in cycles 4..6
      next_sid = 1;
      got      = 0;
      hold_sid = '0;
      hold_val = '0;
      for (int c = 1; c <= 40 && got < 6; c++) begin
         b3.out_ready = !(c >= 4 && c <= 6);
         if (next_sid <= 6) drive3(next_sid);
         else               b3.in_valid = 1'b0;
         #2;
         if (c == 4) begin
            chk("bp.in_ready_drop", 64'(b3.in_ready), 64'd0);
            chk("bp.held_ops", 64'(next_sid - 1 - got), 64'd3);
            hold_sid = b3.out_sid;
            hold_val = b3.out_rd_value;
         end
         if (c == 5 || c == 6) begin
            chk("bp.stall_valid", 64'(b3.out_valid), 64'd1);
            chk("bp.stall_sid", 64'(b3.out_sid), 64'(hold_sid));
            chk("bp.stall_value", b3.out_rd_value, hold_val);
         end
         if (b3.out_valid && b3.out_ready) begin
            got++;
            chk("bp.order_sid", 64'(b3.out_sid), 64'(got));
            chk("bp.rd", 64'(b3.out_rd), 64'(got));
            chk("bp.value", b3.out_rd_value, 64'(got * 17));
            $display("tx bp cycle=%0d sid=%0d rd=%0d value=%h", c, b3.out_sid, b3.out_rd, b3.out_rd_value);
         end
         if (b3.in_valid && b3.in_ready) next_sid++;
         @(posedge clk); #1;
      end
      b3.in_valid = 1'b0;
      chk("bp.delivered", 64'(got), 64'd6);
      for (int k = 0; k < 3; k++) begin
         chk("bp.no_repeat", 64'(b3.out_valid), 64'd0);
         @(posedge clk); #1;
      end

      // Flush with three ops in flight plus a new input in the flush cycle
      b3.out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         drive3(k);
         @(posedge clk); #1;
      end
      b3.in_valid = 1'b0;
      chk("flush.pre_valid", 64'(b3.out_valid), 64'd1);
      b3.out_ready = 1'b1;
      b3.flush     = 1'b1;
      drive3(7);
      @(posedge clk); #1;
      b3.flush    = 1'b0;
      b3.in_valid = 1'b0;
      $display("tx flush out_valid=%0b", b3.out_valid);
      chk("flush.next_valid", 64'(b3.out_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("flush.dropped_input", 64'(b3.out_valid), 64'd0);
      end
      drive3(8);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         b3.in_valid = 1'b0;
         chk("flush.after_latency", 64'(b3.out_valid), 64'(k == 3));
      end
      chk("flush.after_sid", 64'(b3.out_sid), 64'd8);
      chk("flush.after_value", b3.out_rd_value, 64'd136);
      $display("tx post-flush sid=%0d value=%h", b3.out_sid, b3.out_rd_value);
      @(posedge clk); #1;

      // Asynchronous reset drops a stalled result without waiting for a clock edge
      b1.out_ready = 1'b0;
      b1.in_valid  = 1'b1;
      b1.in_inst   = enc_i(12'h003, 3'b000, OP_IMM);
      b1.rs1_value = 64'd4;
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      chk("arst.before", 64'(b1.out_valid), 64'd1);
      chk("arst.value", b1.out_rd_value, 64'd7);
      rst_n = 1'b0;
      #1;
      chk("arst.dropped", 64'(b1.out_valid), 64'd0);
      $display("tx async-reset out_valid=%0b", b1.out_valid);
      @(posedge clk); #1;
      rst_n = 1'b1;
      b1.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("arst.idle", 64'(b1.out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
